cpu_control_fsm: RTL and testbench
==================================

Name: cpu_control_fsm

Overview:
Multi-cycle control sequencer for the 16-bit CPU. It steps each instruction through fetch, decode, execute, memory and writeback, using the decoder's instr_type and ALU opcode outputs. It drives the PC, instruction register, register file, flags register and the shared single-port memory enables. There is one shared memory port for instruction fetch and data, so this FSM also serialises access to it.

Parameters:
MEM_LAT, 1, memory read latency in cycles from address presentation to valid data; legal range 0..7.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
reset_n  in  1  asynchronous active-low reset.
run  in  1  start/continue gate; sampled only at instruction boundaries.
instr_type  in  3  decoder class: 000 ALU, 001 STORE, 010 LOAD, 011 JCOND, 100 BCOND, 101 JAL.
alu_op  in  8  decoder instruction_out (ALU opcode).
cond_met  in  1  condition evaluator result for the current JCOND/BCOND.
state  out  4  current state, for debug and the bench.
ir_we  out  1  instruction register load.
pc_we  out  1  PC update.
pc_sel  out  2  PC next value: 00 PC+1, 01 PC+sign-extended displacement, 10 Rtarget.
addr_sel  out  1  memory address select: 0 PC, 1 register operand.
mem_we  out  1  memory write strobe.
rf_we  out  1  register file write.
wb_sel  out  2  writeback source: 00 ALU, 01 memory data, 10 PC+1.
flags_we  out  1  flags register write.
instr_done  out  1  one-cycle pulse on the last cycle of every instruction.

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, STORE=3, LOAD=4, JUMP=5, BRANCH=6, JAL=7, NOP=8. Values 9-15 are unreachable; if entered, go to FETCH.
- 3-bit wait counter wcnt.
- Reset (asynchronous, reset_n=0): state=FETCH, wcnt=MEM_LAT. Every output not listed for FETCH below is 0; wb_sel=00, pc_sel=00.
- Outputs are Moore-decoded from state and wcnt. The only exceptions are pc_sel in JUMP/BRANCH (follows cond_met) and rf_we/flags_we in EXEC (follow alu_op).
- Reset assertion mid-instruction aborts the instruction immediately. No partial write occurs after reset is asserted.
- FETCH:
  - addr_sel=0.
  - If run=0 while wcnt==MEM_LAT (idle entry): stay in FETCH, hold wcnt, no strobes.
  - Otherwise decrement wcnt each cycle while wcnt>0.
  - When wcnt==0: ir_we=1, then go to DECODE and reload wcnt=MEM_LAT.
  - Once counting has started, run is ignored until the instruction completes.
- DECODE: one cycle, no strobes. Dispatch on instr_type: 000→EXEC, 001→STORE, 010→LOAD, 011→JUMP, 100→BRANCH, 101→JAL. Any other value, including X/Z, goes to NOP.
- EXEC:
  - rf_we=1 unless alu_op==8'h0B (CMP).
  - flags_we=1 for alu_op in {8'h05 ADD, 8'h09 SUB, 8'h0B CMP}.
  - wb_sel=00, pc_we=1, pc_sel=00.
- STORE: addr_sel=1, mem_we=1 for exactly one cycle, pc_we=1, pc_sel=00.
- LOAD:
  - addr_sel=1 held for the whole state; wcnt counts down from MEM_LAT.
  - When wcnt==0: rf_we=1, wb_sel=01, pc_we=1, pc_sel=00.
- JUMP: pc_we=1; pc_sel=10 if cond_met, else 00.
- BRANCH: pc_we=1; pc_sel=01 if cond_met, else 00.
- JAL: rf_we=1, wb_sel=10, pc_we=1, pc_sel=10 (unconditional).
- NOP: pc_we=1, pc_sel=00, no other strobes.
- Terminal states: EXEC, STORE, NOP, JUMP, BRANCH, JAL, and LOAD at wcnt==0.
  - Assert instr_done=1 and return to FETCH with wcnt=MEM_LAT.
  - pc_we is asserted exactly once per instruction, always in the terminal cycle.
- Latency with MEM_LAT=L:
  - ALU/STORE/JUMP/BRANCH/JAL/NOP take L+3 cycles.
  - LOAD takes 2L+3 cycles.
- MEM_LAT=0: FETCH and LOAD are single-cycle (ir_we, or the LOAD writeback, in the first cycle).
- Mutual exclusions: mem_we and ir_we are never high together; mem_we=1 implies addr_sel=1.

Test Plan:
- Reset/idle: MEM_LAT=1, hold reset_n=0, then release with run=0 → state=0, all strobes 0 for 10 cycles.
- ALU op: instr_type=000, alu_op=8'h05 → state sequence 0,0,1,2. ir_we in cycle 2, rf_we=flags_we=pc_we=instr_done=1 in cycle 4. CMP (8'h0B) gives rf_we=0, flags_we=1.
- LOAD with MEM_LAT=2 → 0,0,0,1,4,4,4 (7 cycles); addr_sel=1 throughout LOAD; rf_we=1 and wb_sel=01 only in cycle 7.
- Control flow:
  - JCOND with cond_met=1 → pc_sel=10.
  - JCOND with cond_met=0 → pc_sel=00.
  - BCOND with cond_met=1 → pc_sel=01.
  - JAL → rf_we=1, wb_sel=10, pc_sel=10.
- Illegal type: instr_type=111, or X in DECODE → NOP state (8), only pc_we and instr_done asserted, then back to FETCH.
- Async reset: assert reset_n=0 mid-LOAD (wcnt=1) → state=0 immediately, no rf_we pulse; resumes fetch after release with run=1.

Source files
------------

// File: rtl/cpu_control_fsm.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit CPU.
// Also arbitrates the single shared memory port between instruction fetch and data access.
module cpu_control_fsm #(
   parameter int unsigned MEM_LAT = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       run,
   input  logic [2:0] instr_type,
   input  logic [7:0] alu_op,
   input  logic       cond_met,
   output logic [3:0] state,
   output logic       ir_we,
   output logic       pc_we,
   output logic [1:0] pc_sel,
   output logic       addr_sel,
   output logic       mem_we,
   output logic       rf_we,
   output logic [1:0] wb_sel,
   output logic       flags_we,
   output logic       instr_done
);

   typedef enum logic [3:0] {
      StFetch  = 4'd0,
      StDecode = 4'd1,
      StExec   = 4'd2,
      StStore  = 4'd3,
      StLoad   = 4'd4,
      StJump   = 4'd5,
      StBranch = 4'd6,
      StJal    = 4'd7,
      StNop    = 4'd8
   } state_e;

   localparam logic [2:0] Lat      = 3'(MEM_LAT);
   localparam logic [1:0] PcInc    = 2'b00;
   localparam logic [1:0] PcDisp   = 2'b01;
   localparam logic [1:0] PcTarget = 2'b10;
   localparam logic [1:0] WbAlu    = 2'b00;
   localparam logic [1:0] WbMem    = 2'b01;
   localparam logic [1:0] WbLink   = 2'b10;

   state_e     state_q, state_d;
   logic [2:0] wcnt_q, wcnt_d;
   logic       idle;

   // Idle only before a fetch has started; once counting begins run is ignored.
   assign idle  = !run && (wcnt_q == Lat);
   assign state = state_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StFetch;
         wcnt_q  <= Lat;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wcnt_d     = wcnt_q;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_sel     = PcInc;
      addr_sel   = 1'b0;
      mem_we     = 1'b0;
      rf_we      = 1'b0;
      wb_sel     = WbAlu;
      flags_we   = 1'b0;
      instr_done = 1'b0;

      case (state_q)
         StFetch: begin
            if (!idle) begin
               if (wcnt_q == 3'd0) begin
                  ir_we   = 1'b1;
                  state_d = StDecode;
                  wcnt_d  = Lat;
               end else begin
                  wcnt_d = wcnt_q - 3'd1;
               end
            end
         end
         StDecode: begin
            unique case (instr_type)
               3'b000:  state_d = StExec;
               3'b001:  state_d = StStore;
               3'b010:  state_d = StLoad;
               3'b011:  state_d = StJump;
               3'b100:  state_d = StBranch;
               3'b101:  state_d = StJal;
               default: state_d = StNop;
            endcase
         end
         StExec: begin
            rf_we    = (alu_op != 8'h0B);
            flags_we = (alu_op == 8'h05) || (alu_op == 8'h09) || (alu_op == 8'h0B);
         end
         StStore: begin
            addr_sel = 1'b1;
            mem_we   = 1'b1;
         end
         StLoad: begin
            addr_sel = 1'b1;
            if (wcnt_q == 3'd0) begin
               rf_we  = 1'b1;
               wb_sel = WbMem;
            end else begin
               wcnt_d = wcnt_q - 3'd1;
            end
         end
         StJump:   pc_sel = cond_met ? PcTarget : PcInc;
         StBranch: pc_sel = cond_met ? PcDisp : PcInc;
         StJal: begin
            rf_we  = 1'b1;
            wb_sel = WbLink;
            pc_sel = PcTarget;
         end
         StNop: ;
         default: begin
            state_d = StFetch;
            wcnt_d  = Lat;
         end
      endcase

      // Terminal cycle: the single PC update of the instruction, then refetch.
      if ((state_q inside {StExec, StStore, StJump, StBranch, StJal, StNop}) ||
          (state_q == StLoad && wcnt_q == 3'd0)) begin
         pc_we      = 1'b1;
         instr_done = 1'b1;
         state_d    = StFetch;
         wcnt_d     = Lat;
      end
   end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Bench for cpu_control_fsm: three instances (MEM_LAT 0/1/2) on shared inputs,
// table vectors, hand sequences and a random run against a position-based model.
module tb_cpu_control_fsm;

   typedef struct packed {
      logic [3:0] state;
      logic       ir_we;
      logic       pc_we;
      logic [1:0] pc_sel;
      logic       addr_sel;
      logic       mem_we;
      logic       rf_we;
      logic [1:0] wb_sel;
      logic       flags_we;
      logic       instr_done;
   } obs_t;

   typedef struct {
      logic [2:0] itype;
      logic [7:0] op;
      logic       cond;
      obs_t       term;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       run = 1'b0;
   logic       cond_met = 1'b0;
   logic [2:0] instr_type = 3'd0;
   logic [7:0] alu_op = 8'd0;
   obs_t       obs[3];
   int         n_cmp = 0;
   int         n_err = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      logic [3:0] state;
      logic       ir_we, pc_we, addr_sel, mem_we, rf_we, flags_we, instr_done;
      logic [1:0] pc_sel, wb_sel;

      cpu_control_fsm #(.MEM_LAT(g)) u_dut (
         .clk        (clk),
         .reset_n    (reset_n),
         .run        (run),
         .instr_type (instr_type),
         .alu_op     (alu_op),
         .cond_met   (cond_met),
         .state      (state),
         .ir_we      (ir_we),
         .pc_we      (pc_we),
         .pc_sel     (pc_sel),
         .addr_sel   (addr_sel),
         .mem_we     (mem_we),
         .rf_we      (rf_we),
         .wb_sel     (wb_sel),
         .flags_we   (flags_we),
         .instr_done (instr_done)
      );

      assign obs[g] = {state, ir_we, pc_we, pc_sel, addr_sel, mem_we, rf_we, wb_sel,
                       flags_we, instr_done};
   end

   function automatic obs_t mk(input int st, input bit ir, input bit pcw, input int pcs,
                               input bit ad, input bit mw, input bit rf, input int wb,
                               input bit fl, input bit dn);
      obs_t o;
      o.state      = 4'(st);
      o.ir_we      = ir;
      o.pc_we      = pcw;
      o.pc_sel     = 2'(pcs);
      o.addr_sel   = ad;
      o.mem_we     = mw;
      o.rf_we      = rf;
      o.wb_sel     = 2'(wb);
      o.flags_we   = fl;
      o.instr_done = dn;
      return o;
   endfunction

   task automatic check(input string name, input obs_t act, input obs_t exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Leaves the bench just after reset release, one unit past a rising edge.
   task automatic do_reset();
      reset_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   // Reference: pos counts cycles since the instruction started; cls is the
   // dispatched state number, chosen when pos reaches the decode slot.
   task automatic model(input int lat, input int pos, input int cls, output obs_t e,
                        output int npos, output int ncls);
      e = '0;
      npos = pos;
      ncls = cls;
      if (pos <= lat) begin
         if (pos != 0 || run) begin
            if (pos == lat) e.ir_we = 1'b1;
            npos = pos + 1;
         end
      end else if (pos == lat + 1) begin
         e.state = 4'd1;
         ncls = (instr_type <= 3'd5) ? int'(instr_type) + 2 : 8;
         npos = pos + 1;
      end else begin
         e.state = 4'(cls);
         npos = 0;
         case (cls)
            2: begin
               e.rf_we    = (alu_op != 8'h0B);
               e.flags_we = (alu_op == 8'h05 || alu_op == 8'h09 || alu_op == 8'h0B);
            end
            3: begin
               e.addr_sel = 1'b1;
               e.mem_we   = 1'b1;
            end
            4: begin
               e.addr_sel = 1'b1;
               if (pos - lat - 2 < lat) npos = pos + 1;
               else begin
                  e.rf_we  = 1'b1;
                  e.wb_sel = 2'b01;
               end
            end
            5: e.pc_sel = cond_met ? 2'b10 : 2'b00;
            6: e.pc_sel = cond_met ? 2'b01 : 2'b00;
            7: begin
               e.rf_we  = 1'b1;
               e.wb_sel = 2'b10;
               e.pc_sel = 2'b10;
            end
            default: ;
         endcase
         if (npos == 0) begin
            e.pc_we      = 1'b1;
            e.instr_done = 1'b1;
         end
      end
   endtask

   initial begin
      vec_t vecs[13];
      obs_t exp_ld[7];
      obs_t e;
      int   pos[3];
      int   cls[3];
      int   np, nc, term;

      vecs[0]  = '{3'd0, 8'h05, 1'b0, mk(2, 0, 1, 0, 0, 0, 1, 0, 1, 1)};
      vecs[1]  = '{3'd0, 8'h0B, 1'b0, mk(2, 0, 1, 0, 0, 0, 0, 0, 1, 1)};
      vecs[2]  = '{3'd0, 8'h01, 1'b1, mk(2, 0, 1, 0, 0, 0, 1, 0, 0, 1)};
      vecs[3]  = '{3'd0, 8'h09, 1'b0, mk(2, 0, 1, 0, 0, 0, 1, 0, 1, 1)};
      vecs[4]  = '{3'd1, 8'h05, 1'b0, mk(3, 0, 1, 0, 1, 1, 0, 0, 0, 1)};
      vecs[5]  = '{3'd2, 8'h05, 1'b0, mk(4, 0, 1, 0, 1, 0, 1, 1, 0, 1)};
      vecs[6]  = '{3'd3, 8'h00, 1'b1, mk(5, 0, 1, 2, 0, 0, 0, 0, 0, 1)};
      vecs[7]  = '{3'd3, 8'h00, 1'b0, mk(5, 0, 1, 0, 0, 0, 0, 0, 0, 1)};
      vecs[8]  = '{3'd4, 8'h00, 1'b1, mk(6, 0, 1, 1, 0, 0, 0, 0, 0, 1)};
      vecs[9]  = '{3'd4, 8'h00, 1'b0, mk(6, 0, 1, 0, 0, 0, 0, 0, 0, 1)};
      vecs[10] = '{3'd5, 8'h05, 1'b0, mk(7, 0, 1, 2, 0, 0, 1, 2, 0, 1)};
      vecs[11] = '{3'd6, 8'h05, 1'b1, mk(8, 0, 1, 0, 0, 0, 0, 0, 0, 1)};
      vecs[12] = '{3'd7, 8'h0B, 1'b1, mk(8, 0, 1, 0, 0, 0, 0, 0, 0, 1)};

      // Reset, then idle with run=0: every latency must stay quiet in FETCH.
      run = 1'b0;
      do_reset();
      for (int c = 0; c < 10; c++) begin
         #1;
         for (int g = 0; g < 3; g++) check($sformatf("idle L%0d c%0d", g, c), obs[g], '0);
         @(posedge clk);
         #1;
      end

      // Table vectors on the MEM_LAT=1 instance.
      for (int i = 0; i < 13; i++) begin
         run        = 1'b1;
         instr_type = vecs[i].itype;
         alu_op     = vecs[i].op;
         cond_met   = vecs[i].cond;
         do_reset();
         term = (vecs[i].itype == 3'd2) ? 4 : 3;
         for (int c = 0; c <= term + 1; c++) begin
            #1;
            if (c == 1) check($sformatf("tbl%0d fetch", i), obs[1], mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
            else if (c == 2) check($sformatf("tbl%0d decode", i), obs[1], mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            else if (c == term) check($sformatf("tbl%0d term", i), obs[1], vecs[i].term);
            else if (c == term + 1) check($sformatf("tbl%0d refetch", i), obs[1], '0);
            @(posedge clk);
            #1;
         end
      end

      // LOAD at MEM_LAT=2: 0,0,0,1,4,4,4 with writeback only in the last cycle.
      exp_ld[0] = '0;
      exp_ld[1] = '0;
      exp_ld[2] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      exp_ld[3] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      exp_ld[4] = mk(4, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      exp_ld[5] = mk(4, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      exp_ld[6] = mk(4, 0, 1, 0, 1, 0, 1, 1, 0, 1);
      instr_type = 3'd2;
      run        = 1'b1;
      do_reset();
      for (int c = 0; c < 7; c++) begin
         #1;
         check($sformatf("load L2 c%0d", c), obs[2], exp_ld[c]);
         @(posedge clk);
         #1;
      end

      // Async reset while LOAD waits at wcnt=1: no writeback may escape.
      do_reset();
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
      end
      #2 reset_n = 1'b0;
      #1 check("async rst now", obs[2], '0);
      @(posedge clk);
      #1 check("async rst held", obs[2], '0);
      reset_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         if (c == 2) check("resume fetch", obs[2], mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
         @(posedge clk);
         #1;
      end

      // Random stimulus on all three latencies against the model.
      do_reset();
      for (int g = 0; g < 3; g++) begin
         pos[g] = 0;
         cls[g] = 0;
      end
      for (int c = 0; c < 900; c++) begin
         if ($urandom_range(0, 149) == 0) begin
            do_reset();
            for (int g = 0; g < 3; g++) pos[g] = 0;
         end
         run        = ($urandom_range(0, 3) != 0);
         instr_type = 3'($urandom_range(0, 7));
         cond_met   = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0:       alu_op = 8'h05;
            1:       alu_op = 8'h09;
            2:       alu_op = 8'h0B;
            default: alu_op = 8'($urandom);
         endcase
         #1;
         for (int g = 0; g < 3; g++) begin
            model(g, pos[g], cls[g], e, np, nc);
            check($sformatf("rand L%0d c%0d", g, c), obs[g], e);
            pos[g] = np;
            cls[g] = nc;
         end
         @(posedge clk);
         #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
